// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: nibble-serial W-bit adder/subtractor with start/abort
// handshake. One 4-bit nibble is processed per clock, so an operation takes
// N_NIB cycles in RUN followed by a single DONE cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op         request (op: 0 = A+B, 1 = A-B), sampled in IDLE/DONE
//   a, b              W-bit operands, latched with start
//   abort             cancel an operation in RUN (clears result and flags)
//   ready, busy, done handshake status (done is a one-cycle pulse)
//   result            A+B or A-B modulo 2^W
//   cout, ovf, zero   carry out (1 = no borrow on subtract), signed overflow,
//                     result == 0
module addsub_seq_ctrl #(
  parameter  int unsigned N_NIB = 4,
  localparam int unsigned W     = 4 * N_NIB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         abort,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic             carry_q,  carry_d;
  logic             op_q,     op_d;
  logic [W-1:0]     a_q,      a_d;
  logic [W-1:0]     b_q,      b_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;
  logic             zero_q,   zero_d;
  logic             ready_q,  ready_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       nib_sum;
  logic [W-1:0]     res_full;
  logic             last_nib;

  // Select the current operand nibbles and merge the new sum nibble into the
  // result; res_full is the complete result once the last nibble is merged.
  always_comb begin
    a_nib    = '0;
    b_nib    = '0;
    res_full = result_q;
    for (int unsigned k = 0; k < N_NIB; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_nib = a_q[4*k +: 4];
        b_nib = b_q[4*k +: 4];
      end
    end
    nib_sum = 5'(a_nib) + 5'(b_nib ^ {4{op_q}}) + 5'(carry_q);
    for (int unsigned k = 0; k < N_NIB; k++) begin
      if (idx_q == IDX_W'(k)) begin
        res_full[4*k +: 4] = nib_sum[3:0];
      end
    end
  end

  assign last_nib = (idx_q == IDX_W'(N_NIB - 1));

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      S_RUN: begin
        if (abort) begin
          // abort takes priority over any start seen in RUN
          state_d  = S_IDLE;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
        end else begin
          result_d = res_full;
          carry_d  = nib_sum[4];
          idx_d    = IDX_W'(idx_q + 1'b1);
          if (last_nib) begin
            state_d = S_DONE;
            idx_d   = '0;
            cout_d  = nib_sum[4];
            // operands of equal sign producing a result of the other sign
            ovf_d   = (a_q[W-1] == (b_q[W-1] ^ op_q)) &&
                      (res_full[W-1] != a_q[W-1]);
            zero_d  = (res_full == '0);
          end
        end
      end
      default: begin
        // IDLE and DONE both accept start; DONE always leaves after one cycle
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          op_d    = op;
          idx_d   = '0;
          carry_d = op;
        end
      end
    endcase

    ready_d = (state_d != S_RUN);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// tb_addsub_seq_ctrl: directed and random checks of addsub_seq_ctrl (N_NIB=4)
// against an integer-arithmetic reference model.
module tb_addsub_seq_ctrl;

  localparam int unsigned N_NIB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        abort;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  addsub_seq_ctrl #(.N_NIB(N_NIB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .abort  (abort),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular and signed integer arithmetic.
  function automatic void model(input logic o, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] r, output logic c,
                                output logic v, output logic z);
    logic [16:0] s;
    int sx, sy, sr;
    if (!o) s = {1'b0, x} + {1'b0, y};
    else    s = {1'b0, x} + {1'b0, ~y} + 17'd1;
    r  = s[15:0];
    c  = s[16];
    sx = int'($signed(x));
    sy = int'($signed(y));
    sr = o ? (sx - sy) : (sx + sy);
    v  = (sr > 32767) || (sr < -32768);
    z  = (r == 16'h0000);
  endfunction

  task automatic chk_cleared(input string tag);
    chk({tag, "_result"}, 32'(result), 32'h0);
    chk({tag, "_cout"},   32'(cout),   32'h0);
    chk({tag, "_ovf"},    32'(ovf),    32'h0);
    chk({tag, "_zero"},   32'(zero),   32'h0);
    chk({tag, "_ready"},  32'(ready),  32'h1);
    chk({tag, "_busy"},   32'(busy),   32'h0);
    chk({tag, "_done"},   32'(done),   32'h0);
  endtask

  // Called at a negedge. mode: 0 normal, 1 stray start on 2nd RUN cycle,
  // 2 abort on 2nd RUN cycle, 3 reset on 3rd RUN cycle.
  // Normal modes return at the negedge where done is high.
  task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y,
                        input int mode, input string tag);
    logic [15:0] er;
    logic ec, ev, ez;
    bit got_done;
    int lat;
    model(o, x, y, er, ec, ev, ez);
    chk({tag, "_ready_at_start"}, 32'(ready), 32'h1);
    start = 1'b1; op = o; a = x; b = y;
    got_done = 1'b0;
    lat = -1;
    for (int e = 1; e <= int'(N_NIB) + 6; e++) begin
      @(negedge clk);
      if (e == 1) begin
        start = 1'b0;
        chk({tag, "_busy_run"},  32'(busy),  32'h1);
        chk({tag, "_ready_run"}, 32'(ready), 32'h0);
      end
      if (mode == 1 && e == 2) begin
        start = 1'b1; op = ~o; a = ~x; b = 16'($urandom);
      end
      if (mode == 1 && e == 3) start = 1'b0;
      if (mode == 2 && e == 2) abort = 1'b1;
      if (mode == 2 && e == 3) begin
        abort = 1'b0;
        chk_cleared({tag, "_abort"});
      end
      if (mode == 3 && e == 3) begin
        rst_n = 1'b0;
        #1;
        chk_cleared({tag, "_rst"});
      end
      if (mode == 3 && e == 4) rst_n = 1'b1;
      if (done && !got_done) begin
        got_done = 1'b1;
        lat = e - 1;
        if (mode <= 1) break;
      end
    end
    if (mode <= 1) begin
      chk({tag, "_done_seen"}, 32'(got_done), 32'h1);
      chk({tag, "_latency"},   32'(lat),      32'(N_NIB));
      chk({tag, "_result"},    32'(result),   32'(er));
      chk({tag, "_cout"},      32'(cout),     32'(ec));
      chk({tag, "_ovf"},       32'(ovf),      32'(ev));
      chk({tag, "_zero"},      32'(zero),     32'(ez));
      chk({tag, "_ready_done"}, 32'(ready),   32'h1);
    end else begin
      chk({tag, "_no_done"}, 32'(got_done), 32'h0);
      chk_cleared({tag, "_after"});
    end
  endtask

  // Called at a DONE negedge with no start pending: pulse must end.
  task automatic chk_pulse_end(input string tag);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done),  32'h0);
    chk({tag, "_idle_ready"},     32'(ready), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0; abort = 1'b0;
    #12;
    chk_cleared("reset");
    @(negedge clk);
    chk_cleared("reset_held");
    rst_n = 1'b1;

    // accepted on the first edge after reset release
    run_op(1'b0, 16'h1234, 16'h0FCD, 0, "add_basic");
    chk("add_basic_lit", 32'(result), 32'h2201);
    chk_pulse_end("add_basic");

    run_op(1'b1, 16'h0005, 16'h0007, 0, "sub_neg");
    chk("sub_neg_lit", 32'(result), 32'hFFFE);
    chk_pulse_end("sub_neg");

    run_op(1'b0, 16'h7FFF, 16'h0001, 0, "add_ovf");
    chk("add_ovf_lit", 32'(ovf), 32'h1);
    chk_pulse_end("add_ovf");

    run_op(1'b1, 16'h8000, 16'h0001, 0, "sub_ovf");
    chk("sub_ovf_lit", 32'(result), 32'h7FFF);
    chk_pulse_end("sub_ovf");

    run_op(1'b1, 16'hABCD, 16'hABCD, 0, "sub_zero");
    chk("sub_zero_lit", 32'(zero), 32'h1);
    // start again during DONE: back-to-back operation
    run_op(1'b0, 16'hFFFF, 16'h0001, 0, "b2b_carry");
    chk_pulse_end("b2b_carry");

    run_op(1'b0, 16'h4321, 16'h1111, 1, "stray_start");
    chk_pulse_end("stray_start");

    run_op(1'b1, 16'h9876, 16'h1234, 2, "abort");
    run_op(1'b0, 16'h0F0F, 16'hF0F1, 3, "reset_mid");

    // random operations, randomly chained back-to-back
    for (int i = 0; i < 12; i++) begin
      run_op(1'($urandom), 16'($urandom), 16'($urandom), 0, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 0) chk_pulse_end($sformatf("rand%0d", i));
    end
    chk_pulse_end("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
